// File: rtl/synchronous_fifo_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : synchronous_fifo_pkg                                  |
// | Purpose  : Shared defaults and pointer-width helper for the      |
// |            synchronous FIFO and its storage array.               |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package synchronous_fifo_pkg;

    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_WIDTH = 16;

    // Pointer width: address bits plus one wrap bit to tell full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : synchronous_fifo_pkg
`default_nettype wire

// File: rtl/synchronous_fifo_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : synchronous_fifo_ram                                  |
// | Purpose  : 1-write / 1-read register array. Writes happen on the |
// |            clock edge; the read port is a plain combinational    |
// |            lookup so the owner can register it as it sees fit.   |
// |            Contents are deliberately not reset.                  |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module synchronous_fifo_ram
    import synchronous_fifo_pkg::*;
#(
    parameter int depth      = DEFAULT_DEPTH,
    parameter int width      = DEFAULT_WIDTH,
    parameter int addr_width = $clog2(depth)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [addr_width-1:0] wr_addr,
    input  logic [width-1:0]      wr_data,
    input  logic [addr_width-1:0] rd_addr,
    output logic [width-1:0]      rd_data
);

    logic [width-1:0] mem [depth];

    // Store the incoming word at the write address when enabled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule : synchronous_fifo_ram
`default_nettype wire

// File: rtl/synchronous_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : synchronous_fifo                                      |
// | Purpose  : Single-clock FIFO with wrap-bit pointers, registered  |
// |            read data (one-clock latency) and combinational       |
// |            full/empty flags derived from the pointers.           |
// |            Optional macro SYNCHRONOUS_FIFO_ERR_FLAGS_EN adds     |
// |            registered overflow/underflow pulse outputs.          |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module synchronous_fifo
    import synchronous_fifo_pkg::*;
#(
    parameter int fifo_depth = DEFAULT_DEPTH,
    parameter int fifo_width = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic [fifo_width-1:0] data_in,
    output logic [fifo_width-1:0] data_out,
    output logic                  full,
    output logic                  empty
`ifdef SYNCHRONOUS_FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int PTR_W  = ptr_width(fifo_depth);
    localparam int ADDR_W = PTR_W - 1;

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  wr_accept;
    logic                  rd_accept;
    logic [fifo_width-1:0] ram_rd_data;

    // Equal pointers mean empty; same address with opposite wrap bits means full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                   (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

    // Flags as they stand before the edge gate each request; this alone makes
    // full+both accept only the read and empty+both accept only the write.
    assign wr_accept = w_en && !full;
    assign rd_accept = r_en && !empty;

    synchronous_fifo_ram #(
        .depth      (fifo_depth),
        .width      (fifo_width),
        .addr_width (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (data_in),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (ram_rd_data)
    );

    // Advance pointers on accepted operations and register the head word on reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            data_out <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_accept) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                data_out <= ram_rd_data;
            end
        end
    end

`ifdef SYNCHRONOUS_FIFO_ERR_FLAGS_EN
    // One-cycle pulses flagging a dropped write or a read attempted while empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= w_en && full;
            underflow <= r_en && empty;
        end
    end
`endif

endmodule : synchronous_fifo
`default_nettype wire

// File: tb/tb_synchronous_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_synchronous_fifo                                   |
// | Purpose  : Self-checking bench for synchronous_fifo using a      |
// |            queue scoreboard as the reference FIFO.               |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_synchronous_fifo;

    localparam int DEPTH = 8;
    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             w_en;
    logic             r_en;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
`ifdef SYNCHRONOUS_FIFO_ERR_FLAGS_EN
    logic             overflow;
    logic             underflow;
`endif

    synchronous_fifo #(
        .fifo_depth (DEPTH),
        .fifo_width (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .w_en      (w_en),
        .r_en      (r_en),
        .data_in   (data_in),
        .data_out  (data_out),
        .full      (full),
        .empty     (empty)
`ifdef SYNCHRONOUS_FIFO_ERR_FLAGS_EN
        ,
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: words pushed on accepted writes, popped on accepted reads.
    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] exp_dout;
    logic             exp_ovf;
    logic             exp_unf;
    int               vectors;
    int               miscompares;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".data_out"}, 32'(data_out), 32'(exp_dout));
        check_eq({tag, ".full"},     32'(full),     32'(model_q.size() == DEPTH));
        check_eq({tag, ".empty"},    32'(empty),    32'(model_q.size() == 0));
`ifdef SYNCHRONOUS_FIFO_ERR_FLAGS_EN
        check_eq({tag, ".overflow"},  32'(overflow),  32'(exp_ovf));
        check_eq({tag, ".underflow"}, 32'(underflow), 32'(exp_unf));
`endif
    endtask

    // One clock of stimulus; the model decides acceptance from pre-edge state.
    task automatic step(input string tag, input logic w, input logic r, input logic [WIDTH-1:0] d);
        bit acc_w;
        bit acc_r;
        @(negedge clk);
        w_en    = w;
        r_en    = r;
        data_in = d;
        acc_w   = w && (model_q.size() < DEPTH);
        acc_r   = r && (model_q.size() > 0);
        @(posedge clk);
        #1;
        if (acc_r) exp_dout = model_q.pop_front();
        if (acc_w) model_q.push_back(d);
        exp_ovf = w && !acc_w;
        exp_unf = r && !acc_r;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag, input logic w, input logic r);
        @(negedge clk);
        rst_n   = 1'b0;
        w_en    = w;
        r_en    = r;
        data_in = 16'hA5A5;
        @(posedge clk);
        #1;
        model_q.delete();
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
        check_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
        w_en  = 1'b0;
        r_en  = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        w_en        = 1'b0;
        r_en        = 1'b0;
        data_in     = '0;
        exp_dout    = '0;
        exp_ovf     = 1'b0;
        exp_unf     = 1'b0;

        // Reset with requests pending: reset must win.
        do_reset("reset", 1'b1, 1'b1);

        // Fill with 0..7; full after the eighth edge.
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0, 16'(i));
        check_eq("fill.full_const", 32'(full), 32'd1);

        // Write while full is dropped.
        step("overflow", 1'b1, 1'b0, 16'hFFFF);

        // Drain: expect 0..7 in order.
        for (int i = 0; i < DEPTH; i++) begin
            step("drain", 1'b0, 1'b1, 16'h0);
            check_eq("drain.order", 32'(data_out), 32'(i));
        end

        // Read while empty: data_out holds 0x0007.
        step("underflow", 1'b0, 1'b1, 16'h0);
        check_eq("underflow.hold", 32'(data_out), 32'h0007);

        // Empty with both requests: only the write lands, no bypass.
        step("empty_both", 1'b1, 1'b1, 16'h0BAD);
        check_eq("empty_both.nobypass", 32'(data_out), 32'h0007);
        step("empty_both_rd", 1'b0, 1'b1, 16'h0);

        // Four entries stored, then ten cycles of simultaneous read/write.
        for (int i = 0; i < 4; i++) step("pre4", 1'b1, 1'b0, 16'(16'h0100 + i));
        for (int i = 0; i < 10; i++) begin
            step("concur", 1'b1, 1'b1, 16'(16'h0200 + i));
            check_eq("concur.occupancy", 32'(model_q.size()), 32'd4);
        end

        // Fill to full, then both requests: read only, full deasserts.
        while (model_q.size() < DEPTH) step("refill", 1'b1, 1'b0, 16'(16'h0300 + model_q.size()));
        step("full_both", 1'b1, 1'b1, 16'hBEEF);
        check_eq("full_both.full", 32'(full), 32'd0);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            step("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 16'($urandom_range(0, 65535)));
        end

        // Reset mid-operation with data stored.
        for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 1'b0, 16'(16'h0400 + i));
        do_reset("mid_reset", 1'b1, 1'b0);
        step("post_rst", 1'b1, 1'b0, 16'h1234);
        step("post_rst_rd", 1'b0, 1'b1, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_synchronous_fifo
`default_nettype wire

// File: doc/synchronous_fifo.md
SYNCHRONOUS_FIFO -- requirements
Module: synchronous_fifo

Interface
REQ-001 Parameter fifo_depth, default 8, SHALL set the number of entries; it SHALL be a power of two, at least 2.
REQ-002 Parameter fifo_width, default 16, SHALL set the data word width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be a synchronous, active-low reset sampled on the clk rising edge.
REQ-005 w_en  input  1  SHALL request a write of data_in.
REQ-006 r_en  input  1  SHALL request a read of the head entry.
REQ-007 data_in  input  fifo_width  SHALL carry the write data.
REQ-008 data_out  output  fifo_width  SHALL carry the registered read data.
REQ-009 full  output  1  SHALL be high when fifo_depth entries are stored.
REQ-010 empty  output  1  SHALL be high when zero entries are stored.

Function
REQ-011 Write accepted SHALL be w_en & !full, using full as it stands before the edge.
REQ-012 Read accepted SHALL be r_en & !empty, using empty as it stands before the edge.
REQ-013 An accepted write SHALL store data_in at the write pointer and advance the write pointer by one.
REQ-014 An accepted read SHALL load the head entry into data_out at the same edge and advance the read pointer; read latency is one clock.
REQ-015 data_out SHALL hold its last value when no read is accepted, including reads attempted while empty.
REQ-016 Pointers SHALL be log2(fifo_depth)+1 bits; the extra MSB is a wrap bit, and the address wraps from fifo_depth-1 to 0.
REQ-017 empty SHALL equal (wr_ptr == rd_ptr); full SHALL equal (address bits equal and wrap bits differ); both SHALL be combinational from registered pointers.
REQ-018 A write attempted while full SHALL be dropped, with no change to storage, pointers or flags.
REQ-019 Simultaneous accepted read and write SHALL both complete in one cycle, leaving the occupancy unchanged.
REQ-020 When full with both w_en and r_en high, only the read SHALL be accepted, and full SHALL deassert at the next edge.
REQ-021 When empty with both w_en and r_en high, only the write SHALL be accepted; the written word SHALL NOT bypass to data_out.
REQ-022 Ordering SHALL be strict first-in, first-out.

Reset
REQ-023 On a clk edge with rst_n low, wr_ptr and rd_ptr SHALL clear to 0 and data_out SHALL clear to 0, giving empty=1 and full=0.
REQ-024 Reset SHALL override any concurrent w_en or r_en, including a reset asserted mid-operation.
REQ-025 Storage array contents need not be reset.

Configuration
REQ-026 Macro SYNCHRONOUS_FIFO_ERR_FLAGS_EN, when defined, SHALL add two outputs, overflow and underflow, each 1 bit.
REQ-027 With the macro defined, overflow SHALL be a registered one-cycle pulse after a write dropped while full; underflow SHALL be a registered one-cycle pulse after a read attempted while empty; both SHALL reset to 0.
REQ-028 Without the macro, these ports and their logic SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-029 Package synchronous_fifo_pkg SHALL hold the default depth and width constants and a pointer-width function (clog2(depth)+1).
REQ-030 Storage SHALL be one sub-module, synchronous_fifo_ram: a 1-write, 1-read, synchronous-write register array.
REQ-031 Pointer and flag logic SHALL reside in the top-level module.

Verification
REQ-032 Reset: hold rst_n=0 for 1 cycle -> empty=1, full=0, data_out=0x0000.
REQ-033 Fill: write 0x0000..0x0007 on 8 consecutive cycles -> full=1 after the 8th edge and empty=0.
REQ-034 Overflow: write 0xFFFF while full -> contents unchanged, full stays 1; overflow pulses if the macro is defined.
REQ-035 Drain: r_en=1 for 8 cycles -> data_out is 0x0000..0x0007 in order, one per edge, and empty=1 after the 8th read.
REQ-036 Underflow: r_en=1 while empty -> data_out holds 0x0007, empty stays 1; underflow pulses if the macro is defined.
REQ-037 Concurrency and wrap: with 4 entries stored, assert w_en and r_en for 10 cycles -> occupancy stays 4, pointers wrap, and FIFO order is preserved.
